// File: rtl/proc_run_sequencer_if.sv
// Memory-port bundle for proc_run_sequencer: host access port, processor data
// port and data RAM port.
//   slave  : the sequencer side (consumes requests, drives grants and RAM)
//   master : the environment side (host, processor core, RAM)
interface proc_run_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              proc_halt;
  logic              proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic [DATA_W-1:0] proc_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  proc_halt, proc_we, proc_addr, proc_wdata,
    input  mem_rdata,
    output host_gnt, host_rvalid, host_rdata, proc_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output proc_halt, proc_we, proc_addr, proc_wdata,
    output mem_rdata,
    input  host_gnt, host_rvalid, host_rdata, proc_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/proc_run_sequencer.sv
// Run controller and data-memory port arbiter for the pipelined reverb
// processor. Holds the core in reset while the host owns data RAM, releases it
// on start (latching the bank select), hands the RAM port to the core during
// RUN/DRAIN, and returns it to the host when the run ends.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, abort    one-cycle run control pulses
//   mode            bank select, captured on an accepted start
//   bus             host / processor / RAM port bundle (slave side)
//   proc_rst        processor reset
//   proc_mode       processor modeSelector
//   busy, done      state is RUN or DRAIN / state is DONE
//   timeout         last run ended on the cycle limit
//   cycles          RUN cycles of the current or last run
module proc_run_sequencer #(
  parameter int               DATA_W    = 32,
  parameter int               ADDR_W    = 32,
  parameter int               CNT_W     = 24,
  parameter logic [CNT_W-1:0] MAX_CYC   = 24'hFFFFFF,
  parameter int unsigned      DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  proc_run_sequencer_if.slave  bus,
  output logic                 proc_rst,
  output logic                 proc_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycles
);

  localparam int DCW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CYC = MAX_CYC - 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [DCW-1:0]    drainCnt;
  logic              hostOwns;
  logic              hostGnt;
  logic              rvalidQ;
  logic [DATA_W-1:0] rdataHold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      proc_rst  <= 1'b1;
      proc_mode <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
      drainCnt  <= '0;
    end else if (abort && state != IDLE) begin
      // abort outranks start/halt/timeout; counters are left for inspection
      state    <= IDLE;
      proc_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            proc_rst  <= 1'b0;
            proc_mode <= mode;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycles    <= '0;
          end
        end
        RUN: begin
          cycles <= cycles + 1'b1;
          if (bus.proc_halt) begin
            state    <= DRAIN;
            drainCnt <= DCW'(DRAIN_CYC);
          end else if (cycles == LAST_CYC) begin
            state    <= DRAIN;
            timeout  <= 1'b1;
            drainCnt <= DCW'(DRAIN_CYC);
          end
        end
        DRAIN: begin
          drainCnt <= drainCnt - 1'b1;
          if (drainCnt <= DCW'(1)) begin
            state    <= DONE;
            proc_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read data appears the cycle after the address; rvalid marks that cycle
  // and host_rdata passes the RAM word through, then holds it afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalidQ   <= 1'b0;
      rdataHold <= '0;
    end else begin
      rvalidQ <= hostGnt & ~bus.host_we;
      if (rvalidQ) rdataHold <= bus.mem_rdata;
    end
  end

  always_comb begin
    hostOwns        = (state == IDLE) || (state == DONE);
    hostGnt         = hostOwns & bus.host_req;
    bus.host_gnt    = hostGnt;
    bus.host_rvalid = rvalidQ;
    bus.host_rdata  = rvalidQ ? bus.mem_rdata : rdataHold;
    bus.proc_rdata  = bus.mem_rdata;
    if (hostOwns) begin
      bus.mem_we    = bus.host_req & bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end else begin
      bus.mem_we    = bus.proc_we;
      bus.mem_addr  = bus.proc_addr;
      bus.mem_wdata = bus.proc_wdata;
    end
  end

endmodule

// File: tb/tb_proc_run_sequencer.sv
module tb_proc_run_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, mode;
  logic proc_rst, proc_mode, busy, done, timeout;
  logic [23:0] cycles;
  logic proc_rst2, proc_mode2, busy2, done2, timeout2;
  logic [23:0] cycles2;

  int nTests = 0;
  int nFail  = 0;

  proc_run_sequencer_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
  proc_run_sequencer_if #(.DATA_W(32), .ADDR_W(32)) b2 ();

  proc_run_sequencer #(.DATA_W(32), .ADDR_W(32), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .bus(b1),
    .proc_rst(proc_rst), .proc_mode(proc_mode), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles)
  );

  // Short cycle limit instance: runs alongside dut, never halted by the core.
  proc_run_sequencer #(.DATA_W(32), .ADDR_W(32), .CNT_W(24), .MAX_CYC(24'd16),
                       .DRAIN_CYC(4)) dutTo (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .bus(b2),
    .proc_rst(proc_rst2), .proc_mode(proc_mode2), .busy(busy2), .done(done2),
    .timeout(timeout2), .cycles(cycles2)
  );

  assign b2.host_req   = 1'b0;
  assign b2.host_we    = 1'b0;
  assign b2.host_addr  = '0;
  assign b2.host_wdata = '0;
  assign b2.proc_halt  = 1'b0;
  assign b2.proc_we    = 1'b0;
  assign b2.proc_addr  = '0;
  assign b2.proc_wdata = '0;
  assign b2.mem_rdata  = '0;

  always #5 clk = ~clk;

  // Data RAM: synchronous read, word addressed.
  logic [31:0] ram [256];
  logic [31:0] ramQ;
  always @(posedge clk) begin
    if (b1.mem_we) ram[b1.mem_addr[9:2]] <= b1.mem_wdata;
    ramQ <= ram[b1.mem_addr[9:2]];
  end
  assign b1.mem_rdata = ramQ;

  logic [31:0] refMem [256];
  logic [31:0] expQ [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every host read pushes its expected word when driven.
  always @(negedge clk) begin
    if (!rst && b1.host_rvalid) begin
      if (expQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL sb_unexpected: got rvalid=1 expected 0 at %0t", $time);
      end else begin
        check("sb_rdata", b1.host_rdata, expQ.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hostAccess(input logic we, input logic [7:0] addr, input logic [31:0] data);
    b1.host_req   = 1'b1;
    b1.host_we    = we;
    b1.host_addr  = {24'h0, addr};
    b1.host_wdata = data;
    if (we) refMem[addr[7:2]] = data;
    else expQ.push_back(refMem[addr[7:2]]);
    #1;
    check("host_gnt", {31'b0, b1.host_gnt}, 32'd1);
    step();
    b1.host_req = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        expGnt;
    logic        expWe;
  } vec_t;

  vec_t vecs [8];
  logic prevRead;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h10, 32'h0000ABCD, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h14, 32'h12345678, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h14, 32'h0,        1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h20, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h20, 32'hCAFEF00D, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    b1.host_req = 1'b0; b1.host_we = 1'b0; b1.host_addr = '0; b1.host_wdata = '0;
    b1.proc_halt = 1'b0; b1.proc_we = 1'b0; b1.proc_addr = '0; b1.proc_wdata = '0;
    #3;
    check("rst_proc_rst", {31'b0, proc_rst}, 32'd1);
    check("rst_busy",     {31'b0, busy}, 32'd0);
    check("rst_done",     {31'b0, done}, 32'd0);
    check("rst_timeout",  {31'b0, timeout}, 32'd0);
    check("rst_cycles",   {8'b0, cycles}, 32'd0);
    check("rst_rvalid",   {31'b0, b1.host_rvalid}, 32'd0);
    check("rst_rdata",    b1.host_rdata, 32'd0);
    check("rst_mem_we",   {31'b0, b1.mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Host access table in IDLE
    prevRead = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b1.host_req   = vecs[i].req;
      b1.host_we    = vecs[i].we;
      b1.host_addr  = {24'h0, vecs[i].addr};
      b1.host_wdata = vecs[i].wdata;
      if (vecs[i].req && vecs[i].we) refMem[vecs[i].addr[7:2]] = vecs[i].wdata;
      if (vecs[i].req && !vecs[i].we) expQ.push_back(refMem[vecs[i].addr[7:2]]);
      #1;
      check("tbl_gnt",    {31'b0, b1.host_gnt}, {31'b0, vecs[i].expGnt});
      check("tbl_mem_we", {31'b0, b1.mem_we}, {31'b0, vecs[i].expWe});
      check("tbl_addr",   b1.mem_addr, {24'h0, vecs[i].addr});
      check("tbl_rvalid", {31'b0, b1.host_rvalid}, {31'b0, prevRead});
      prevRead = vecs[i].req & ~vecs[i].we;
      step();
    end
    b1.host_req = 1'b0;
    step();

    // Start with mode=1, host read in the start cycle is still granted
    mode = 1'b1; start = 1'b1;
    hostAccess(1'b0, 8'h10, 32'h0);
    start = 1'b0; mode = 1'b0;
    check("run_proc_rst",  {31'b0, proc_rst}, 32'd0);
    check("run_proc_mode", {31'b0, proc_mode}, 32'd1);
    check("run_busy",      {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 100; k++) begin
      if (k == 2) begin
        b1.host_req = 1'b1; b1.host_we = 1'b1; b1.host_addr = 32'h30; b1.host_wdata = 32'h77;
      end
      if (k == 3) begin
        b1.proc_we = 1'b1; b1.proc_addr = 32'h40; b1.proc_wdata = 32'h5555;
        refMem[8'h40 >> 2] = 32'h5555;
      end
      if (k == 4) begin
        b1.proc_we = 1'b0; b1.host_req = 1'b0;
      end
      if (k == 100) b1.proc_halt = 1'b1;
      #1;
      if (k == 2) begin
        check("run_host_gnt", {31'b0, b1.host_gnt}, 32'd0);
        check("run_mem_we0",  {31'b0, b1.mem_we}, 32'd0);
      end
      if (k == 3) begin
        check("run_mem_we1",  {31'b0, b1.mem_we}, 32'd1);
        check("run_mem_addr", b1.mem_addr, 32'h40);
        check("run_mem_wd",   b1.mem_wdata, 32'h5555);
      end
      if (k == 5) check("run_cycles5", {8'b0, cycles}, 32'd4);
      if (k == 16) check("to_not_yet", {31'b0, timeout2}, 32'd0);
      if (k == 17) begin
        check("to_timeout", {31'b0, timeout2}, 32'd1);
        check("to_cycles",  {8'b0, cycles2}, 32'd16);
      end
      if (k == 20) begin
        check("to_drain_busy", {31'b0, busy2}, 32'd1);
        check("to_drain_done", {31'b0, done2}, 32'd0);
      end
      if (k == 21) begin
        check("to_done", {31'b0, done2}, 32'd1);
        check("to_busy", {31'b0, busy2}, 32'd0);
      end
      if (k == 100) check("run_cycles99", {8'b0, cycles}, 32'd99);
      step();
    end
    // DRAIN cycle 1 (halt still high: ignored outside RUN)
    check("drain_cycles", {8'b0, cycles}, 32'd100);
    check("drain_busy",   {31'b0, busy}, 32'd1);
    b1.proc_halt = 1'b0;
    step();
    // DRAIN cycle 2: store still lands
    b1.proc_we = 1'b1; b1.proc_addr = 32'h44; b1.proc_wdata = 32'hD2A1;
    refMem[8'h44 >> 2] = 32'hD2A1;
    #1;
    check("drain_mem_we", {31'b0, b1.mem_we}, 32'd1);
    check("drain_addr",   b1.mem_addr, 32'h44);
    step();
    b1.proc_we = 1'b0;
    step();
    check("drain4_done", {31'b0, done}, 32'd0);
    step();
    check("done_done",     {31'b0, done}, 32'd1);
    check("done_busy",     {31'b0, busy}, 32'd0);
    check("done_proc_rst", {31'b0, proc_rst}, 32'd1);
    check("done_cycles",   {8'b0, cycles}, 32'd100);
    check("done_timeout",  {31'b0, timeout}, 32'd0);
    check("done_mode",     {31'b0, proc_mode}, 32'd1);
    hostAccess(1'b0, 8'h44, 32'h0);
    hostAccess(1'b0, 8'h40, 32'h0);
    step();

    // Restart from DONE with mode=0, start ignored in RUN, abort beats halt
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("re_done",     {31'b0, done}, 32'd0);
    check("re_mode",     {31'b0, proc_mode}, 32'd0);
    check("re_timeout2", {31'b0, timeout2}, 32'd0);
    check("re_done2",    {31'b0, done2}, 32'd0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("re_ign_start", {8'b0, cycles}, 32'd2);
    b1.proc_halt = 1'b1; abort = 1'b1;
    step();
    b1.proc_halt = 1'b0; abort = 1'b0;
    check("ab_busy",     {31'b0, busy}, 32'd0);
    check("ab_done",     {31'b0, done}, 32'd0);
    check("ab_proc_rst", {31'b0, proc_rst}, 32'd1);
    check("ab_cycles",   {8'b0, cycles}, 32'd2);
    repeat (6) step();
    check("ab_stay_idle", {31'b0, done}, 32'd0);
    hostAccess(1'b0, 8'h14, 32'h0);

    // Asynchronous reset in the middle of a run
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_proc_rst", {31'b0, proc_rst}, 32'd1);
    check("mid_rst_busy",     {31'b0, busy}, 32'd0);
    check("mid_rst_cycles",   {8'b0, cycles}, 32'd0);
    check("mid_rst_mode",     {31'b0, proc_mode}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    hostAccess(1'b0, 8'h20, 32'h0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    step();
    step();
    check("sb_empty", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
